// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage between the PC register and IF/ID.
//
// Takes the registered fetch PC and its exception vector and runs one
// SRAM-like transaction (request / address-accept / data-return) on the
// instruction bus. It then presents the fetched word, its PC and its
// exception bits to decode. While a fetch is outstanding it requests a
// pipeline stall. Responses that belong to flushed fetches are discarded.
//
// Optional feature: define INST_KSEG_MAP_EN to turn on kseg0/kseg1 address
// translation. With it, bits [31:29] are cleared when addr[31:30] == 2'b10.
// Without it, the bus address equals the fetch PC.
//
// Ports:
//   clk, reset        core clock; asynchronous active-low reset
//   stall[5:0]        stall[0] = PC stage held, stall[1] = this stage held
//   flush             kills the current fetch and the output register
//   i_pc, i_except    fetch PC (0 = bubble) and exception vector (bit1 = AdEL)
//   inst_req/addr     bus request, held until inst_addr_ok
//   inst_addr_ok      address accepted
//   inst_data_ok      read data valid
//   inst_rdata        read data
//   o_inst/o_pc/o_except/o_valid  registered outputs to decode
//   stallreq          combinational stall request
module inst_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] i_pc,
  input  logic [6:0]  i_except,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [6:0]  o_except,
  output logic        o_valid,
  output logic        stallreq
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [6:0]  req_exc_q, req_exc_d;
  logic        cancel_q, cancel_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic [6:0]  exc_q, exc_d;
  logic        valid_q, valid_d;

  logic        load;
  logic [31:0] ld_inst, ld_pc;
  logic [6:0]  ld_exc;
  logic [31:0] addr_map;
  logic        unused_stall;

  assign unused_stall = ^stall[5:2];

`ifdef INST_KSEG_MAP_EN
  always_comb begin
    addr_map = req_pc_q;
    if (req_pc_q[31:30] == 2'b10) addr_map = {3'b000, req_pc_q[28:0]};
  end
`else
  always_comb addr_map = req_pc_q;
`endif

  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    req_exc_d = req_exc_q;
    cancel_d  = cancel_q;
    inst_req  = 1'b0;
    inst_addr = '0;
    stallreq  = 1'b0;
    load      = 1'b0;
    ld_inst   = '0;
    ld_pc     = '0;
    ld_exc    = '0;

    case (state_q)
      IDLE: begin
        if (!flush && i_pc != '0) begin
          if (!i_except[1]) begin
            req_pc_d  = i_pc;
            req_exc_d = i_except;
            state_d   = REQ;
            stallreq  = 1'b1;
          end else begin
            // AdEL: complete immediately without touching the bus
            load    = 1'b1;
            ld_pc   = i_pc;
            ld_exc  = i_except;
            state_d = stall[0] ? DONE : IDLE;
          end
        end
      end
      REQ: begin
        // The request is never withdrawn; a flush only marks it for discard
        inst_req  = 1'b1;
        inst_addr = addr_map;
        stallreq  = 1'b1;
        if (inst_addr_ok) state_d = WAIT;
        if (flush) cancel_d = 1'b1;
      end
      WAIT: begin
        stallreq = !(inst_data_ok && !cancel_q);
        if (inst_data_ok) begin
          state_d  = IDLE;
          cancel_d = 1'b0;
          if (!cancel_q) begin
            load    = 1'b1;
            ld_inst = inst_rdata;
            ld_pc   = req_pc_q;
            ld_exc  = req_exc_q;
            if (stall[0] && !flush) state_d = DONE;
          end
        end else if (flush) begin
          cancel_d = 1'b1;
        end
      end
      DONE: begin
        if (flush || !stall[0]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flush beats a same-cycle load; otherwise an unstalled stage drains to a bubble
  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    exc_d   = exc_q;
    valid_d = valid_q;
    if (flush) begin
      inst_d  = '0;
      pc_d    = '0;
      exc_d   = '0;
      valid_d = 1'b0;
    end else if (load) begin
      inst_d  = ld_inst;
      pc_d    = ld_pc;
      exc_d   = ld_exc;
      valid_d = 1'b1;
    end else if (!stall[1]) begin
      inst_d  = '0;
      pc_d    = '0;
      exc_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      req_pc_q  <= '0;
      req_exc_q <= '0;
      cancel_q  <= 1'b0;
      inst_q    <= '0;
      pc_q      <= '0;
      exc_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      req_exc_q <= req_exc_d;
      cancel_q  <= cancel_d;
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      exc_q     <= exc_d;
      valid_q   <= valid_d;
    end
  end

  assign o_inst   = inst_q;
  assign o_pc     = pc_q;
  assign o_except = exc_q;
  assign o_valid  = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] i_pc;
  logic [6:0]  i_except;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic [6:0]  o_except;
  logic        o_valid;
  logic        stallreq;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .i_pc(i_pc), .i_except(i_except),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .o_inst(o_inst), .o_pc(o_pc), .o_except(o_except),
    .o_valid(o_valid), .stallreq(stallreq)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] kmap(input logic [31:0] a);
`ifdef INST_KSEG_MAP_EN
    if (a[31:30] == 2'b10) return a & 32'h1FFF_FFFF;
`endif
    return a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic [6:0]  exc;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_sreq;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic [6:0]  e_exc;
  } vec_t;

  function automatic vec_t mk(
      input logic [5:0] st, input logic fl, input logic [31:0] pc, input logic [6:0] ex,
      input logic aok, input logic dok, input logic [31:0] rd,
      input logic e_req, input logic [31:0] e_addr, input logic e_sreq,
      input logic e_valid, input logic [31:0] e_inst, input logic [31:0] e_pc,
      input logic [6:0] e_exc);
    vec_t v;
    v.stall = st; v.flush = fl; v.pc = pc; v.exc = ex;
    v.aok = aok; v.dok = dok; v.rdata = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_sreq = e_sreq;
    v.e_valid = e_valid; v.e_inst = e_inst; v.e_pc = e_pc; v.e_exc = e_exc;
    return v;
  endfunction

  task automatic drive(input logic [5:0] st, input logic fl, input logic [31:0] pc,
                       input logic [6:0] ex, input logic aok, input logic dok,
                       input logic [31:0] rd);
    stall = st; flush = fl; i_pc = pc; i_except = ex;
    inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd;
  endtask

  // One cycle: drive at negedge, check combinational outputs, then check registers after the edge
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    drive(v.stall, v.flush, v.pc, v.exc, v.aok, v.dok, v.rdata);
    #1;
    chk({tag, ".inst_req"}, {31'b0, inst_req}, {31'b0, v.e_req});
    chk({tag, ".inst_addr"}, inst_addr, v.e_addr);
    chk({tag, ".stallreq"}, {31'b0, stallreq}, {31'b0, v.e_sreq});
    @(posedge clk);
    #1;
    chk({tag, ".o_valid"}, {31'b0, o_valid}, {31'b0, v.e_valid});
    chk({tag, ".o_inst"}, o_inst, v.e_inst);
    chk({tag, ".o_pc"}, o_pc, v.e_pc);
    chk({tag, ".o_except"}, {25'b0, o_except}, {25'b0, v.e_exc});
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".o_valid"}, {31'b0, o_valid}, 32'h0);
    chk({tag, ".o_inst"}, o_inst, 32'h0);
    chk({tag, ".o_pc"}, o_pc, 32'h0);
    chk({tag, ".o_except"}, {25'b0, o_except}, 32'h0);
    chk({tag, ".inst_req"}, {31'b0, inst_req}, 32'h0);
    chk({tag, ".inst_addr"}, inst_addr, 32'h0);
    chk({tag, ".stallreq"}, {31'b0, stallreq}, 32'h0);
  endtask

  // Transaction-level reference: a pending fetch record plus a "completed, PC held" flag
  logic        m_busy, m_acc, m_cancel, m_hold;
  logic [31:0] m_pc;
  logic [6:0]  m_exc;
  logic        m_valid;
  logic [31:0] m_inst, m_opc;
  logic [6:0]  m_oexc;

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SS = 6'b000011;

  vec_t tbl[$];

  initial begin
    reset = 1'b0;
    drive(S0, 1'b0, 32'h0, 7'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk_zero_outputs("reset");

    // basic fetch: addr_ok one cycle after req, data_ok two cycles later
    tbl.push_back(mk(SS,0,32'hBFC0_0000,0,0,0,0,          0,0,1,                   0,0,0,0));
    tbl.push_back(mk(SS,0,32'hBFC0_0000,0,0,0,0,          1,kmap(32'hBFC0_0000),1, 0,0,0,0));
    tbl.push_back(mk(SS,0,32'hBFC0_0000,0,1,0,0,          1,kmap(32'hBFC0_0000),1, 0,0,0,0));
    tbl.push_back(mk(SS,0,32'hBFC0_0000,0,0,0,0,          0,0,1,                   0,0,0,0));
    tbl.push_back(mk(S0,0,32'hBFC0_0000,0,0,1,32'h2408_0001, 0,0,0, 1,32'h2408_0001,32'hBFC0_0000,0));
    // AdEL: one edge, no bus access
    tbl.push_back(mk(S0,0,32'hBFC0_0002,7'b0000010,0,0,0, 0,0,0, 1,0,32'hBFC0_0002,7'b0000010));
    tbl.push_back(mk(S0,0,32'h0,0,0,0,0,                  0,0,0, 0,0,0,0));
    // flush in WAIT, late data discarded
    tbl.push_back(mk(SS,0,32'hBFC0_0004,0,0,0,0,          0,0,1,                   0,0,0,0));
    tbl.push_back(mk(SS,0,32'hBFC0_0004,0,1,0,0,          1,kmap(32'hBFC0_0004),1, 0,0,0,0));
    tbl.push_back(mk(SS,1,32'hBFC0_0004,0,0,0,0,          0,0,1,                   0,0,0,0));
    tbl.push_back(mk(SS,0,32'hBFC0_0004,0,0,0,0,          0,0,1,                   0,0,0,0));
    tbl.push_back(mk(SS,0,32'hBFC0_0004,0,0,1,32'hDEAD_BEEF, 0,0,1,                0,0,0,0));
    tbl.push_back(mk(S0,0,32'hBFC0_000A,7'b0000010,0,0,0, 0,0,0, 1,0,32'hBFC0_000A,7'b0000010));
    tbl.push_back(mk(S0,0,32'h0,0,0,0,0,                  0,0,0, 0,0,0,0));
    // flush in REQ, addr_ok delayed: request held, response discarded
    tbl.push_back(mk(SS,0,32'hBFC0_0010,0,0,0,0,          0,0,1,                   0,0,0,0));
    tbl.push_back(mk(SS,1,32'hBFC0_0010,0,0,0,0,          1,kmap(32'hBFC0_0010),1, 0,0,0,0));
    tbl.push_back(mk(SS,0,32'hBFC0_0010,0,0,0,0,          1,kmap(32'hBFC0_0010),1, 0,0,0,0));
    tbl.push_back(mk(SS,0,32'hBFC0_0010,0,1,0,0,          1,kmap(32'hBFC0_0010),1, 0,0,0,0));
    tbl.push_back(mk(SS,0,32'hBFC0_0010,0,0,1,32'h1234_5678, 0,0,1,                0,0,0,0));
    tbl.push_back(mk(S0,0,32'h0,0,0,0,0,                  0,0,0, 0,0,0,0));
    // stall held after completion: no re-fetch, outputs held
    tbl.push_back(mk(SS,0,32'hBFC0_0020,0,0,0,0,          0,0,1,                   0,0,0,0));
    tbl.push_back(mk(SS,0,32'hBFC0_0020,0,1,0,0,          1,kmap(32'hBFC0_0020),1, 0,0,0,0));
    tbl.push_back(mk(SS,0,32'hBFC0_0020,0,0,1,32'h8C82_0000, 0,0,0, 1,32'h8C82_0000,32'hBFC0_0020,0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(SS,0,32'hBFC0_0020,0,0,0,0,        0,0,0, 1,32'h8C82_0000,32'hBFC0_0020,0));
    tbl.push_back(mk(S0,0,32'hBFC0_0020,0,0,0,0,          0,0,0, 0,0,0,0));
    tbl.push_back(mk(SS,0,32'hBFC0_0024,0,0,0,0,          0,0,1,                   0,0,0,0));
    tbl.push_back(mk(SS,0,32'hBFC0_0024,0,1,0,0,          1,kmap(32'hBFC0_0024),1, 0,0,0,0));
    tbl.push_back(mk(S0,0,32'hBFC0_0024,0,0,1,32'h3C01_0000, 0,0,0, 1,32'h3C01_0000,32'hBFC0_0024,0));
    // start another fetch with outputs held, for the reset sequence below
    tbl.push_back(mk(SS,0,32'hBFC0_0030,0,0,0,0,          0,0,1,                   1,32'h3C01_0000,32'hBFC0_0024,0));
    tbl.push_back(mk(SS,0,32'hBFC0_0030,0,1,0,0,          1,kmap(32'hBFC0_0030),1, 1,32'h3C01_0000,32'hBFC0_0024,0));

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // reset asserted mid-WAIT: outputs clear immediately
    @(negedge clk);
    drive(SS, 1'b0, 32'h0, 7'h0, 1'b0, 1'b0, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk_zero_outputs("rst_mid");
    @(posedge clk);
    #1;
    chk_zero_outputs("rst_hold");
    @(negedge clk);
    reset = 1'b1;
    // stray data_ok after release is ignored
    apply(mk(S0,0,32'h0,0,0,1,32'hCAFE_F00D, 0,0,0, 0,0,0,0), "stray0");
    apply(mk(SS,0,32'h0,0,0,1,32'h0BAD_0BAD, 0,0,0, 0,0,0,0), "stray1");

    // randomized run against the reference model, starting from the idle state
    m_busy = 0; m_acc = 0; m_cancel = 0; m_hold = 0;
    m_pc = '0; m_exc = '0;
    m_valid = 0; m_inst = '0; m_opc = '0; m_oexc = '0;
    for (int c = 0; c < 3000; c++) begin
      logic [5:0]  r_st;
      logic        r_fl, r_aok, r_dok, start, ld, e_req, e_sreq;
      logic [31:0] r_pc, r_rd, e_addr, l_inst, l_pc;
      logic [6:0]  r_ex, l_exc;
      int unsigned sel, bsel;
      r_st = 6'($urandom_range(0, 63));
      r_fl = ($urandom_range(0, 99) < 8);
      sel  = $urandom_range(0, 3);
      r_ex = 7'($urandom_range(0, 127));
      if (sel == 0) begin
        r_pc = 32'h0; r_ex = 7'h0;
      end else if (sel == 3) begin
        r_pc = $urandom() | 32'h2; r_ex = r_ex | 7'b0000010;
      end else begin
        r_pc = ($urandom() & 32'hFFFF_FFF0) | 32'h8; r_ex = r_ex & 7'b1111101;
      end
      bsel  = $urandom_range(0, 9);
      r_aok = (bsel < 3);
      r_dok = (bsel >= 3 && bsel < 6);
      r_rd  = $urandom();

      @(negedge clk);
      drive(r_st, r_fl, r_pc, r_ex, r_aok, r_dok, r_rd);
      #1;
      start  = !m_busy && !m_hold && !r_fl && r_pc != 0 && !r_ex[1];
      e_req  = m_busy && !m_acc;
      e_addr = e_req ? kmap(m_pc) : 32'h0;
      e_sreq = (m_busy && !(m_acc && r_dok && !m_cancel)) || start;
      chk("rnd.inst_req", {31'b0, inst_req}, {31'b0, e_req});
      chk("rnd.inst_addr", inst_addr, e_addr);
      chk("rnd.stallreq", {31'b0, stallreq}, {31'b0, e_sreq});

      ld = 0; l_inst = 0; l_pc = 0; l_exc = 0;
      if (m_hold) begin
        if (r_fl || !r_st[0]) m_hold = 0;
      end else if (!m_busy) begin
        if (!r_fl && r_pc != 0) begin
          if (!r_ex[1]) begin
            m_busy = 1; m_acc = 0; m_pc = r_pc; m_exc = r_ex;
          end else begin
            ld = 1; l_pc = r_pc; l_exc = r_ex; m_hold = r_st[0];
          end
        end
      end else if (!m_acc) begin
        if (r_aok) m_acc = 1;
        if (r_fl) m_cancel = 1;
      end else if (r_dok) begin
        m_busy = 0;
        if (!m_cancel) begin
          ld = 1; l_inst = r_rd; l_pc = m_pc; l_exc = m_exc;
          m_hold = r_st[0] && !r_fl;
        end
        m_cancel = 0;
      end else if (r_fl) begin
        m_cancel = 1;
      end
      if (r_fl || (!ld && !r_st[1])) begin
        m_valid = 0; m_inst = 0; m_opc = 0; m_oexc = 0;
      end else if (ld) begin
        m_valid = 1; m_inst = l_inst; m_opc = l_pc; m_oexc = l_exc;
      end

      @(posedge clk);
      #1;
      chk("rnd.o_valid", {31'b0, o_valid}, {31'b0, m_valid});
      chk("rnd.o_inst", o_inst, m_inst);
      chk("rnd.o_pc", o_pc, m_opc);
      chk("rnd.o_except", {25'b0, o_except}, {25'b0, m_oexc});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
